// File: rtl/pipe_hazard_ctrl_if.sv
// Pipeline hazard interface: RR/EX/MEM status in, pipeline-register load/flush controls out.
// master = pipeline datapath side, slave = hazard controller.
interface pipe_hazard_ctrl_if #(
  parameter int REG_ADDR_W = 3,
  parameter int CNT_W      = 16
);
  logic                  rr_valid;
  logic                  rr_uses_src1;
  logic                  rr_uses_src2;
  logic [REG_ADDR_W-1:0] rr_src1;
  logic [REG_ADDR_W-1:0] rr_src2;
  logic                  ex_valid;
  logic                  ex_is_load;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  ex_br_taken;
  logic                  mem_busy;

  logic                  pc_ld;
  logic                  ld_if_id;
  logic                  ld_id_rr;
  logic                  ld_rr_ex;
  logic                  ld_ex_mem;
  logic                  ld_mem_wb;
  logic                  flush_if_id;
  logic                  flush_id_rr;
  logic                  bubble_rr_ex;
  logic [CNT_W-1:0]      stall_cycles;
  logic [CNT_W-1:0]      flush_events;

  modport master (
    output rr_valid, rr_uses_src1, rr_uses_src2, rr_src1, rr_src2,
           ex_valid, ex_is_load, ex_dest, ex_br_taken, mem_busy,
    input  pc_ld, ld_if_id, ld_id_rr, ld_rr_ex, ld_ex_mem, ld_mem_wb,
           flush_if_id, flush_id_rr, bubble_rr_ex, stall_cycles, flush_events
  );

  modport slave (
    input  rr_valid, rr_uses_src1, rr_uses_src2, rr_src1, rr_src2,
           ex_valid, ex_is_load, ex_dest, ex_br_taken, mem_busy,
    output pc_ld, ld_if_id, ld_id_rr, ld_rr_ex, ld_ex_mem, ld_mem_wb,
           flush_if_id, flush_id_rr, bubble_rr_ex, stall_cycles, flush_events
  );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Load-enable / flush / bubble control for a 6-stage pipeline (load-use, branch, memory wait).
// Define PIPE_HAZARD_PERF_EN to build the saturating stall/flush performance counters.
module pipe_hazard_ctrl #(
  parameter int REG_ADDR_W = 3,
  parameter int LU_STALL   = 1,
  parameter int CNT_W      = 16
) (
  input logic              clk,
  input logic              reset,
  pipe_hazard_ctrl_if.slave hz
);

  typedef enum logic {RUN, LU_WAIT} fsm_t;
  typedef enum logic [2:0] {M_RESET, M_FREEZE, M_BRANCH, M_STALL, M_NORMAL} mode_t;

  fsm_t                  fsm, fsm_nxt;
  logic [1:0]            lu_cnt, lu_cnt_nxt;
  logic [REG_ADDR_W-1:0] ex_dest;
  logic                  lu_hit;
  mode_t                 mode;

  assign ex_dest = hz.ex_dest;
  assign lu_hit  = hz.rr_valid & hz.ex_valid & hz.ex_is_load &
                   ((hz.rr_uses_src1 & (hz.rr_src1 == ex_dest)) |
                    (hz.rr_uses_src2 & (hz.rr_src2 == ex_dest)));

  // Priority: reset > memory freeze > taken branch > load-use > normal.
  always_comb begin
    if (reset)                              mode = M_RESET;
    else if (hz.mem_busy)                   mode = M_FREEZE;
    else if (hz.ex_br_taken)                mode = M_BRANCH;
    else if ((fsm == LU_WAIT) || lu_hit)    mode = M_STALL;
    else                                    mode = M_NORMAL;
  end

  // NOTE: state flops use non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (reset) begin
      fsm    <= RUN;
      lu_cnt <= 2'd0;
    end else begin
      fsm    <= fsm_nxt;
      lu_cnt <= lu_cnt_nxt;
    end
  end

  // NOTE: defaults first in every always_comb so no path leaves a signal unassigned (no latches).
  always_comb begin
    fsm_nxt    = fsm;
    lu_cnt_nxt = lu_cnt;
    unique case (mode)
      M_BRANCH: begin
        fsm_nxt    = RUN;
        lu_cnt_nxt = 2'd0;
      end
      M_STALL: begin
        if (fsm == LU_WAIT) begin
          lu_cnt_nxt = lu_cnt - 2'd1;
          if (lu_cnt == 2'd1) fsm_nxt = RUN;
        end else if (LU_STALL > 1) begin
          fsm_nxt    = LU_WAIT;
          lu_cnt_nxt = 2'(LU_STALL - 1);
        end
      end
      default: ;
    endcase
  end

  always_comb begin
    hz.pc_ld        = 1'b0;
    hz.ld_if_id     = 1'b0;
    hz.ld_id_rr     = 1'b0;
    hz.ld_rr_ex     = 1'b0;
    hz.ld_ex_mem    = 1'b0;
    hz.ld_mem_wb    = 1'b0;
    hz.flush_if_id  = 1'b0;
    hz.flush_id_rr  = 1'b0;
    hz.bubble_rr_ex = 1'b0;
    unique case (mode)
      M_NORMAL, M_BRANCH: begin
        hz.pc_ld     = 1'b1;
        hz.ld_if_id  = 1'b1;
        hz.ld_id_rr  = 1'b1;
        hz.ld_rr_ex  = 1'b1;
        hz.ld_ex_mem = 1'b1;
        hz.ld_mem_wb = 1'b1;
        if (mode == M_BRANCH) begin
          hz.flush_if_id  = 1'b1;
          hz.flush_id_rr  = 1'b1;
          hz.bubble_rr_ex = 1'b1;
        end
      end
      M_STALL: begin
        // Front end holds the dependent instruction; a NOP drains into EX.
        hz.ld_rr_ex     = 1'b1;
        hz.ld_ex_mem    = 1'b1;
        hz.ld_mem_wb    = 1'b1;
        hz.bubble_rr_ex = 1'b1;
      end
      default: ;
    endcase
  end

`ifdef PIPE_HAZARD_PERF_EN
  logic [CNT_W-1:0] stall_q, flush_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (((mode == M_FREEZE) || (mode == M_STALL)) && (stall_q != '1))
        stall_q <= stall_q + 1'b1;
      if ((mode == M_BRANCH) && (flush_q != '1))
        flush_q <= flush_q + 1'b1;
    end
  end

  assign hz.stall_cycles = stall_q;
  assign hz.flush_events = flush_q;
`else
  assign hz.stall_cycles = {CNT_W{1'b0}};
  assign hz.flush_events = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Bench for pipe_hazard_ctrl: LU_STALL=1 and LU_STALL=3 instances share stimulus; directed table,
// reset-mid-stall sequence and random cycles against a remaining-stall-count reference model.
module tb_pipe_hazard_ctrl;
  localparam int AW = 3;
  localparam int CW = 4;
  localparam logic [8:0] O_ZERO  = 9'b000000_000;
  localparam logic [8:0] O_NORM  = 9'b111111_000;
  localparam logic [8:0] O_STALL = 9'b000111_001;
  localparam logic [8:0] O_BR    = 9'b111111_111;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) if1 ();
  pipe_hazard_ctrl_if #(.REG_ADDR_W(AW), .CNT_W(CW)) if3 ();

  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .LU_STALL(1), .CNT_W(CW)) dut1 (.clk(clk), .reset(reset), .hz(if1));
  pipe_hazard_ctrl #(.REG_ADDR_W(AW), .LU_STALL(3), .CNT_W(CW)) dut3 (.clk(clk), .reset(reset), .hz(if3));

  wire logic [8:0] o1 = {if1.pc_ld, if1.ld_if_id, if1.ld_id_rr, if1.ld_rr_ex, if1.ld_ex_mem,
                         if1.ld_mem_wb, if1.flush_if_id, if1.flush_id_rr, if1.bubble_rr_ex};
  wire logic [8:0] o3 = {if3.pc_ld, if3.ld_if_id, if3.ld_id_rr, if3.ld_rr_ex, if3.ld_ex_mem,
                         if3.ld_mem_wb, if3.flush_if_id, if3.flush_id_rr, if3.bubble_rr_ex};

  typedef struct packed {
    logic rst, rv, u1, u2;
    logic [AW-1:0] s1, s2;
    logic ev, ld;
    logic [AW-1:0] dst;
    logic br, busy;
  } in_t;

  typedef struct {
    in_t        in;
    logic [8:0] e1;
    logic [8:0] e3;
  } vec_t;

  vec_t vecs[$];
  int errors = 0;
  int checks = 0;

  // Reference model: number of forced stall cycles still owed, plus event counts.
  int left[2];
  int sc[2];
  int fc[2];
  int lst[2] = '{1, 3};

  function automatic in_t mk(logic rst, logic rv, logic u1, logic u2, int s1, int s2,
                             logic ev, logic ld, int dst, logic br, logic busy);
    in_t i;
    i.rst = rst; i.rv = rv; i.u1 = u1; i.u2 = u2;
    i.s1 = AW'(s1); i.s2 = AW'(s2);
    i.ev = ev; i.ld = ld; i.dst = AW'(dst); i.br = br; i.busy = busy;
    return i;
  endfunction

  function automatic bit hit(in_t i);
    return i.rv && i.ev && i.ld && ((i.u1 && i.s1 == i.dst) || (i.u2 && i.s2 == i.dst));
  endfunction

  function automatic int exp_cnt(int v);
`ifdef PIPE_HAZARD_PERF_EN
    return v;
`else
    return 0;
`endif
  endfunction

  task automatic model_step(input in_t i, input int k, output logic [8:0] o);
    int mx;
    mx = (1 << CW) - 1;
    if (i.rst) begin
      o = O_ZERO; left[k] = 0; sc[k] = 0; fc[k] = 0;
    end else if (i.busy) begin
      o = O_ZERO;
      if (sc[k] < mx) sc[k]++;
    end else if (i.br) begin
      o = O_BR; left[k] = 0;
      if (fc[k] < mx) fc[k]++;
    end else if (left[k] > 0) begin
      o = O_STALL; left[k]--;
      if (sc[k] < mx) sc[k]++;
    end else if (hit(i)) begin
      o = O_STALL; left[k] = lst[k] - 1;
      if (sc[k] < mx) sc[k]++;
    end else begin
      o = O_NORM;
    end
  endtask

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply(input in_t i);
    reset = i.rst;
    if1.rr_valid = i.rv;  if3.rr_valid = i.rv;
    if1.rr_uses_src1 = i.u1; if3.rr_uses_src1 = i.u1;
    if1.rr_uses_src2 = i.u2; if3.rr_uses_src2 = i.u2;
    if1.rr_src1 = i.s1;   if3.rr_src1 = i.s1;
    if1.rr_src2 = i.s2;   if3.rr_src2 = i.s2;
    if1.ex_valid = i.ev;  if3.ex_valid = i.ev;
    if1.ex_is_load = i.ld; if3.ex_is_load = i.ld;
    if1.ex_dest = i.dst;  if3.ex_dest = i.dst;
    if1.ex_br_taken = i.br; if3.ex_br_taken = i.br;
    if1.mem_busy = i.busy; if3.mem_busy = i.busy;
  endtask

  // One cycle: drive after negedge, sample 1ns later, then advance the model past the next edge.
  task automatic step(input in_t i, input bit use_tab, input logic [8:0] e1, input logic [8:0] e3,
                      input string tag);
    logic [8:0] m1, m3;
    @(negedge clk);
    apply(i);
    #1;
    check({tag, " stall_cycles L1"}, 32'(if1.stall_cycles), exp_cnt(sc[0]));
    check({tag, " flush_events L1"}, 32'(if1.flush_events), exp_cnt(fc[0]));
    check({tag, " stall_cycles L3"}, 32'(if3.stall_cycles), exp_cnt(sc[1]));
    check({tag, " flush_events L3"}, 32'(if3.flush_events), exp_cnt(fc[1]));
    model_step(i, 0, m1);
    model_step(i, 1, m3);
    check({tag, " outputs L1"}, 32'(o1), 32'(use_tab ? e1 : m1));
    check({tag, " outputs L3"}, 32'(o3), 32'(use_tab ? e3 : m3));
  endtask

  initial begin
    in_t idle, haz, hazb, r;
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    haz  = mk(0, 1, 1, 0, 3, 0, 1, 1, 3, 0, 0);
    hazb = mk(0, 1, 1, 0, 3, 0, 0, 1, 3, 0, 0);

    for (int k = 0; k < 2; k++) begin
      left[k] = 0; sc[k] = 0; fc[k] = 0;
    end
    r = idle; r.rst = 1'b1;
    apply(r);
    repeat (2) @(posedge clk);

    for (int k = 0; k < 3; k++) vecs.push_back('{r, O_ZERO, O_ZERO});
    vecs.push_back('{idle, O_NORM, O_NORM});
    vecs.push_back('{haz,  O_STALL, O_STALL});
    vecs.push_back('{hazb, O_NORM, O_STALL});
    vecs.push_back('{hazb, O_NORM, O_STALL});
    vecs.push_back('{hazb, O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 1, 0, 3, 0, 1, 1, 3, 1, 0), O_BR, O_BR});
    vecs.push_back('{idle, O_NORM, O_NORM});
    for (int k = 0; k < 4; k++) vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1), O_ZERO, O_ZERO});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0), O_BR, O_BR});
    vecs.push_back('{idle, O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 1, 1, 5, 0, 1, 1, 0, 0, 0), O_STALL, O_STALL});
    vecs.push_back('{mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1), O_ZERO, O_ZERO});
    vecs.push_back('{idle, O_NORM, O_STALL});
    vecs.push_back('{idle, O_NORM, O_STALL});
    vecs.push_back('{idle, O_NORM, O_NORM});
    vecs.push_back('{mk(0, 0, 1, 0, 3, 0, 1, 1, 3, 0, 0), O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 0, 0, 3, 0, 1, 1, 3, 0, 0), O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 1, 0, 3, 0, 1, 0, 3, 0, 0), O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 1, 1, 3, 3, 1, 1, 4, 0, 0), O_NORM, O_NORM});
    vecs.push_back('{mk(0, 1, 0, 1, 6, 7, 1, 1, 7, 0, 0), O_STALL, O_STALL});
    vecs.push_back('{idle, O_NORM, O_STALL});
    vecs.push_back('{idle, O_NORM, O_STALL});
    vecs.push_back('{idle, O_NORM, O_NORM});

    foreach (vecs[n]) step(vecs[n].in, 1'b1, vecs[n].e1, vecs[n].e3, $sformatf("vec%0d", n));

    // Reset one cycle into a 3-cycle load-use stall abandons it.
    step(haz,  1'b1, O_STALL, O_STALL, "midrst stall");
    step(r,    1'b1, O_ZERO,  O_ZERO,  "midrst reset");
    step(hazb, 1'b1, O_NORM,  O_NORM,  "midrst release");
    step(idle, 1'b1, O_NORM,  O_NORM,  "midrst idle");

    for (int n = 0; n < 600; n++) begin
      in_t x;
      x.rst  = ($urandom_range(0, 59) == 0);
      x.rv   = ($urandom_range(0, 3) != 0);
      x.u1   = $urandom_range(0, 1) == 1;
      x.u2   = $urandom_range(0, 1) == 1;
      x.s1   = AW'($urandom_range(0, 3));
      x.s2   = AW'($urandom_range(0, 3));
      x.ev   = ($urandom_range(0, 3) != 0);
      x.ld   = ($urandom_range(0, 2) != 0);
      x.dst  = AW'($urandom_range(0, 3));
      x.br   = ($urandom_range(0, 7) == 0);
      x.busy = ($urandom_range(0, 5) == 0);
      step(x, 1'b0, O_ZERO, O_ZERO, $sformatf("rnd%0d", n));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/pipe_hazard_ctrl.md
Name: pipe_hazard_ctrl

Overview:
- Drives the load-enable (ld) and bubble/flush controls of the 6-stage pipeline registers (IF, ID, RR, EX, MEM, WB).
- The registers capture data; this block decides, every cycle, which of them load, which hold, and which take a NOP.
- Handles load-use stalls, taken-branch flushes and data-memory wait freezes.

Parameters:
- REG_ADDR_W, 3, width of register-file addresses compared for hazards.
- LU_STALL, 1, bubble cycles per load-use hazard; legal range 1..3.
- CNT_W, 16, width of the optional performance counters.

Ports:
- clk  input  1  single clock; all state updates on the rising edge.
- reset  input  1  synchronous, active-high reset.
- rr_valid  input  1  RR stage holds a real instruction.
- rr_uses_src1  input  1  RR instruction reads src1.
- rr_uses_src2  input  1  RR instruction reads src2.
- rr_src1  input  REG_ADDR_W  RR source address 1.
- rr_src2  input  REG_ADDR_W  RR source address 2.
- ex_valid  input  1  EX stage holds a real instruction.
- ex_is_load  input  1  EX instruction is a load.
- ex_dest  input  REG_ADDR_W  EX destination address.
- ex_br_taken  input  1  branch or jump resolved taken in EX.
- mem_busy  input  1  data memory not ready; the MEM access must repeat.
- pc_ld  output  1  PC register load enable.
- ld_if_id, ld_id_rr, ld_rr_ex, ld_ex_mem, ld_mem_wb  output  1 each  pipeline register load enables.
- flush_if_id, flush_id_rr  output  1 each  load a NOP into that register this cycle.
- bubble_rr_ex  output  1  RR/EX loads a NOP; asserted for load-use and for branch flush.
- stall_cycles  output  CNT_W  optional counter; see Optional Feature.
- flush_events  output  CNT_W  optional counter; see Optional Feature.

Behaviour:
- Outputs are combinational from the registered state, the counter and the current inputs. Zero latency: a hazard seen in cycle N gates the loads at the edge ending cycle N.
- Registered state: fsm in {RUN, LU_WAIT} and lu_cnt (2 bits).
- Reset (reset=1 at an edge):
  - fsm is set to RUN, lu_cnt to 0 and the counters to 0.
  - While reset is high, every output is 0.
  - A reset in mid-stall abandons the stall.
- lu_hit = rr_valid & ex_valid & ex_is_load & ((rr_uses_src1 & rr_src1==ex_dest) | (rr_uses_src2 & rr_src2==ex_dest)). All addresses are compared, including 0.
- Priority, highest first: reset > mem_busy > ex_br_taken > lu_hit/LU_WAIT > normal.
- FREEZE (mem_busy=1, any state):
  - All ld and pc_ld are 0; all flush and bubble outputs are 0.
  - fsm and lu_cnt hold.
  - A pending ex_br_taken or lu_hit is acted on in the first cycle with mem_busy=0.
- BRANCH (ex_br_taken=1, mem_busy=0, any state):
  - pc_ld=1 and all ld=1.
  - flush_if_id=1, flush_id_rr=1, bubble_rr_ex=1.
  - Next fsm is RUN and lu_cnt is 0. A simultaneous lu_hit is ignored because the RR instruction is being flushed.
- LOAD-USE from RUN (lu_hit=1, no freeze, no branch):
  - pc_ld=0, ld_if_id=0, ld_id_rr=0.
  - ld_rr_ex=1 with bubble_rr_ex=1; ld_ex_mem=1, ld_mem_wb=1.
  - If LU_STALL=1, fsm stays RUN. Otherwise fsm goes to LU_WAIT and lu_cnt is set to LU_STALL-1.
- LU_WAIT (no freeze, no branch):
  - Outputs are the same as LOAD-USE.
  - lu_cnt decrements each cycle. When lu_cnt==1 at the edge, fsm returns to RUN.
  - lu_hit is not re-evaluated while in LU_WAIT.
- NORMAL (RUN, no hazard): pc_ld and all ld are 1; flush and bubble are 0.
- Invariant: a flush or bubble output is never 1 while its register's ld is 0.

Optional Feature:
- Macro: PIPE_HAZARD_PERF_EN.
- Defined:
  - stall_cycles increments on every non-reset cycle with pc_ld=0 (freeze and load-use).
  - flush_events increments on every BRANCH cycle.
  - Both counters saturate at all-ones and clear on reset.
- Undefined: both ports are present and tied to 0; no counter flops are built.

Test Plan:
- Reset held 3 cycles, then released with idle inputs -> every output 0 during reset; first cycle after release pc_ld=1 and all ld=1.
- LU_STALL=1: ex_is_load, ex_dest=3, rr_src1=3, rr_uses_src1 -> one cycle with pc_ld=ld_if_id=ld_id_rr=0 and ld_rr_ex=bubble_rr_ex=1; next cycle, with EX holding the bubble, NORMAL.
- LU_STALL=3, same hazard -> exactly 3 consecutive stall cycles, then NORMAL; stall_cycles=3 when PIPE_HAZARD_PERF_EN is defined.
- ex_br_taken=1 together with lu_hit=1 -> BRANCH outputs (pc_ld=1, all flushes and bubble=1), no stall next cycle; flush_events=1.
- mem_busy=1 for 4 cycles while ex_br_taken=1 -> 4 cycles with all ld=0 and no flush; in the 5th cycle (mem_busy=0) BRANCH outputs.
- Enter LU_WAIT (LU_STALL=3), then assert reset after the 1st stall cycle -> all outputs 0; after release NORMAL, with lu_cnt and counters at 0.
